// File: rtl/psram64_writer.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------------
// Module     : psram64_writer
// Description: QPI PSRAM burst writer (0x38, 24-bit addr, 32 bytes per burst).
//              Optional macro PSRAM_WR_BYTESWAP_EN swaps FIFO bytes on capture.
// Revision   : 1.0
//------------------------------------------------------------------------------
module psram64_writer (
   input  logic        clk,
   input  logic        reset,
   input  logic        psram_ready,
   input  logic [9:0]  wrfifo_rdusedw,
   output logic        wrfifo_rdreq,
   input  logic [15:0] wrfifo_q,
   input  logic        addr_load,
   input  logic [22:0] addr_in,
   output logic        PSRAM_CEn,
   output logic        PSRAM_CLK,
   output logic [3:0]  PSRAM_SIO_OUT,
   output logic        PSRAM_SIO_DIR,
   output logic        PSRAM_CMD_DIR,
   output logic        busy,
   output logic        burst_done
);

   localparam logic [9:0]  c_burst_hw    = 10'd16;
   localparam logic [22:0] c_burst_bytes = 23'd32;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_CMD  = 3'd1,
      S_ADDR = 3'd2,
      S_DATA = 3'd3,
      S_GAP  = 3'd4
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [5:0]  r_cnt, w_cnt_nxt;
   logic [22:0] r_addr_ptr, r_pend_addr;
   logic        r_pend;
   logic [15:0] r_shreg;
   logic [15:0] w_word;
   logic [23:0] w_addr24;
   logic [3:0]  w_addr_nib;
   logic        w_burst_end;

`ifdef PSRAM_WR_BYTESWAP_EN
   assign w_word = {wrfifo_q[7:0], wrfifo_q[15:8]};
`else
   assign w_word = wrfifo_q;
`endif

   assign PSRAM_CLK = clk;
   assign w_addr24  = {1'b0, r_addr_ptr};

   always_comb begin
      w_addr_nib = 4'hF;
      case (r_cnt[2:0])
         3'd0:    w_addr_nib = w_addr24[23:20];
         3'd1:    w_addr_nib = w_addr24[19:16];
         3'd2:    w_addr_nib = w_addr24[15:12];
         3'd3:    w_addr_nib = w_addr24[11:8];
         3'd4:    w_addr_nib = w_addr24[7:4];
         3'd5:    w_addr_nib = w_addr24[3:0];
         default: w_addr_nib = 4'hF;
      endcase
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt + 6'd1;
      w_burst_end   = 1'b0;
      PSRAM_CEn     = 1'b1;
      PSRAM_SIO_DIR = 1'b0;
      PSRAM_CMD_DIR = 1'b0;
      PSRAM_SIO_OUT = 4'hF;
      wrfifo_rdreq  = 1'b0;
      burst_done    = 1'b0;
      busy          = (r_state != S_IDLE);
      case (r_state)
         S_IDLE: begin
            w_cnt_nxt = 6'd0;
            if (psram_ready && (wrfifo_rdusedw >= c_burst_hw))
               w_state_nxt = S_CMD;
         end
         S_CMD: begin
            PSRAM_CEn     = 1'b0;
            PSRAM_SIO_DIR = 1'b1;
            PSRAM_CMD_DIR = 1'b1;
            PSRAM_SIO_OUT = (r_cnt == 6'd0) ? 4'h3 : 4'h8;
            if (r_cnt == 6'd1) begin
               w_state_nxt = S_ADDR;
               w_cnt_nxt   = 6'd0;
            end
         end
         S_ADDR: begin
            PSRAM_CEn     = 1'b0;
            PSRAM_SIO_DIR = 1'b1;
            PSRAM_CMD_DIR = 1'b1;
            PSRAM_SIO_OUT = w_addr_nib;
            // First pop lands exactly on DATA nibble 0
            if (r_cnt == 6'd5) begin
               wrfifo_rdreq = 1'b1;
               w_state_nxt  = S_DATA;
               w_cnt_nxt    = 6'd0;
            end
         end
         S_DATA: begin
            PSRAM_CEn     = 1'b0;
            PSRAM_SIO_DIR = 1'b1;
            PSRAM_CMD_DIR = 1'b1;
            PSRAM_SIO_OUT = (r_cnt[1:0] == 2'd0) ? w_word[15:12] : r_shreg[15:12];
            wrfifo_rdreq  = (r_cnt[1:0] == 2'd3) && (r_cnt != 6'd63);
            if (r_cnt == 6'd63) begin
               w_state_nxt = S_GAP;
               w_cnt_nxt   = 6'd0;
            end
         end
         S_GAP: begin
            if (r_cnt == 6'd1) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = 6'd0;
               w_burst_end = 1'b1;
               burst_done  = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 6'd0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= 6'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Nibble 0 of each word comes straight from the FIFO; the rest drain from here
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_shreg <= 16'd0;
      end else if (r_state == S_DATA) begin
         if (r_cnt[1:0] == 2'd0)
            r_shreg <= {w_word[11:0], 4'h0};
         else
            r_shreg <= {r_shreg[11:0], 4'h0};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_addr_ptr  <= 23'd0;
         r_pend      <= 1'b0;
         r_pend_addr <= 23'd0;
      end else if (w_burst_end) begin
         if (addr_load)
            r_addr_ptr <= addr_in;
         else if (r_pend)
            r_addr_ptr <= r_pend_addr;
         else
            r_addr_ptr <= r_addr_ptr + c_burst_bytes;
         r_pend <= 1'b0;
      end else if (addr_load) begin
         if (r_state == S_IDLE) begin
            r_addr_ptr <= addr_in;
         end else begin
            r_pend      <= 1'b1;
            r_pend_addr <= addr_in;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_psram64_writer.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------------
// Module     : tb_psram64_writer
// Description: Scoreboard bench for psram64_writer (QPI nibble stream checks).
// Revision   : 1.0
//------------------------------------------------------------------------------
module tb_psram64_writer;

   logic        clk = 1'b0;
   logic        reset;
   logic        psram_ready;
   logic [9:0]  wrfifo_rdusedw;
   logic        wrfifo_rdreq;
   logic [15:0] wrfifo_q;
   logic        addr_load;
   logic [22:0] addr_in;
   logic        PSRAM_CEn, PSRAM_CLK, PSRAM_SIO_DIR, PSRAM_CMD_DIR;
   logic [3:0]  PSRAM_SIO_OUT;
   logic        busy, burst_done;

   psram64_writer dut (
      .clk(clk), .reset(reset), .psram_ready(psram_ready),
      .wrfifo_rdusedw(wrfifo_rdusedw), .wrfifo_rdreq(wrfifo_rdreq),
      .wrfifo_q(wrfifo_q), .addr_load(addr_load), .addr_in(addr_in),
      .PSRAM_CEn(PSRAM_CEn), .PSRAM_CLK(PSRAM_CLK),
      .PSRAM_SIO_OUT(PSRAM_SIO_OUT), .PSRAM_SIO_DIR(PSRAM_SIO_DIR),
      .PSRAM_CMD_DIR(PSRAM_CMD_DIR), .busy(busy), .burst_done(burst_done)
   );

   always #5 clk = ~clk;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [3:0] exp_q[$];
   int         fidx = 0;
   int         ce_cyc = 0, rd_cnt = 0, done_cnt = 0, busy_cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] word_at(input int k);
      logic [15:0] w;
      w = 16'h1234 + 16'(k) * 16'h4444;
      return w;
   endfunction

   function automatic logic [15:0] exp_word(input int k);
      logic [15:0] w;
      w = word_at(k);
`ifdef PSRAM_WR_BYTESWAP_EN
      w = {w[7:0], w[15:8]};
`endif
      return w;
   endfunction

   // External FIFO model: data appears one cycle after the pop request
   always @(posedge clk) begin
      if (wrfifo_rdreq === 1'b1 && reset === 1'b0) begin
         #1;
         wrfifo_q = word_at(fidx);
         fidx++;
      end
   end

   always @(negedge clk) begin
      logic [3:0] e;
      if (reset === 1'b0) begin
         if (PSRAM_CEn === 1'b0) begin
            ce_cyc++;
            if (exp_q.size() == 0) begin
               check("sio_unexpected_nibble", {28'd0, PSRAM_SIO_OUT}, 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("sio_nibble", {28'd0, PSRAM_SIO_OUT}, {28'd0, e});
               check("drive_enables", {30'd0, PSRAM_SIO_DIR, PSRAM_CMD_DIR}, 32'd3);
            end
         end else begin
            check("idle_pads", {26'd0, PSRAM_SIO_OUT, PSRAM_SIO_DIR, PSRAM_CMD_DIR},
                  {26'd0, 4'hF, 2'b00});
         end
         if (wrfifo_rdreq === 1'b1) rd_cnt++;
         if (burst_done === 1'b1) done_cnt++;
         if (busy === 1'b1) busy_cyc++;
      end
   end

   task automatic start_burst(input logic [22:0] a, input int base);
      logic [23:0] a24;
      logic [15:0] w;
      a24 = {1'b0, a};
      fidx = base;
      exp_q.push_back(4'h3);
      exp_q.push_back(4'h8);
      for (int i = 0; i < 6; i++) exp_q.push_back(a24[23 - 4*i -: 4]);
      for (int k = 0; k < 16; k++) begin
         w = exp_word(base + k);
         exp_q.push_back(w[15:12]);
         exp_q.push_back(w[11:8]);
         exp_q.push_back(w[7:4]);
         exp_q.push_back(w[3:0]);
      end
      @(negedge clk); #1;
      ce_cyc = 0; rd_cnt = 0; done_cnt = 0; busy_cyc = 0;
      wrfifo_rdusedw = 10'd16;
      @(negedge clk); #1;
      check("start_next_cycle", {31'd0, busy}, 32'd1);
      wrfifo_rdusedw = 10'd0;
   endtask

   task automatic finish_burst();
      int k;
      k = 0;
      while (done_cnt == 0 && k < 200) begin
         @(negedge clk); #1;
         k++;
      end
      check("burst_done_seen", done_cnt, 1);
      repeat (2) begin @(negedge clk); #1; end
      check("cen_low_cycles", ce_cyc, 72);
      check("rdreq_pulses", rd_cnt, 16);
      check("burst_done_pulses", done_cnt, 1);
      check("busy_cycles", busy_cyc, 74);
      check("scoreboard_drained", exp_q.size(), 0);
   endtask

   initial begin
      int bad;
      int k;
      reset = 1'b1; psram_ready = 1'b1; wrfifo_rdusedw = 10'd0;
      addr_load = 1'b0; addr_in = 23'd0; wrfifo_q = 16'd0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_cen", {31'd0, PSRAM_CEn}, 32'd1);
      check("rst_sio_out", {28'd0, PSRAM_SIO_OUT}, 32'hF);
      check("rst_dirs", {30'd0, PSRAM_SIO_DIR, PSRAM_CMD_DIR}, 32'd0);
      check("rst_busy_done_rdreq", {29'd0, busy, burst_done, wrfifo_rdreq}, 32'd0);
      reset = 1'b0;

      // One halfword short of a burst, then FIFO full but PSRAM not ready
      wrfifo_rdusedw = 10'd15;
      bad = 0;
      repeat (20) begin
         @(negedge clk); #1;
         if (PSRAM_CEn !== 1'b1 || busy !== 1'b0) bad++;
      end
      check("rdusedw15_stays_idle", bad, 0);
      wrfifo_rdusedw = 10'd16; psram_ready = 1'b0;
      bad = 0;
      repeat (10) begin
         @(negedge clk); #1;
         if (PSRAM_CEn !== 1'b1 || busy !== 1'b0) bad++;
      end
      check("not_ready_stays_idle", bad, 0);
      wrfifo_rdusedw = 10'd0; psram_ready = 1'b1;

      start_burst(23'h000000, 0);   finish_burst();
      start_burst(23'h000020, 16);  finish_burst();

      // Wrap at the top of the address space
      @(negedge clk); #1; addr_load = 1'b1; addr_in = 23'h7FFFE0;
      @(negedge clk); #1; addr_load = 1'b0;
      start_burst(23'h7FFFE0, 32);  finish_burst();
      start_burst(23'h000000, 48);  finish_burst();

      // Load during DATA is deferred to burst end
      start_burst(23'h000020, 64);
      repeat (20) begin @(negedge clk); #1; end
      addr_load = 1'b1; addr_in = 23'h100000;
      @(negedge clk); #1; addr_load = 1'b0;
      finish_burst();
      start_burst(23'h100000, 80);
      repeat (20) begin @(negedge clk); #1; end
      addr_load = 1'b1; addr_in = 23'h200000;
      @(negedge clk); #1; addr_load = 1'b0;
      k = 0;
      while (burst_done !== 1'b1 && k < 200) begin @(negedge clk); #1; k++; end
      check("gap_end_reached", {31'd0, burst_done}, 32'd1);
      addr_load = 1'b1; addr_in = 23'h555500;
      @(negedge clk); #1; addr_load = 1'b0;
      finish_burst();
      start_burst(23'h555500, 96);  finish_burst();

      // Reset in the middle of DATA nibble 30
      start_burst(23'h555520, 112);
      k = 0;
      while (ce_cyc < 39 && k < 200) begin @(negedge clk); #1; k++; end
      check("reached_nibble30", ce_cyc, 39);
      reset = 1'b1;
      #1;
      check("async_cen", {31'd0, PSRAM_CEn}, 32'd1);
      check("async_sio_dir", {30'd0, PSRAM_SIO_DIR, PSRAM_CMD_DIR}, 32'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      #1; reset = 1'b0;
      rd_cnt = 0; busy_cyc = 0;
      repeat (10) begin @(negedge clk); #1; end
      check("post_reset_no_rdreq", rd_cnt, 0);
      check("post_reset_not_busy", busy_cyc, 0);
      start_burst(23'h000000, 0);   finish_burst();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
